// File: rtl/sync_packet_mirror_fifo.sv
// Store-and-forward AXI-stream packet FIFO that passively mirrors an upstream
// handshake. Accepted beats go to a data FIFO, and each packet's length goes to
// a packet FIFO. Complete packets are replayed with tlast rebuilt from the
// stored length.
module sync_packet_mirror_fifo #(
    parameter int DSIZE      = 8,
    parameter int KSIZE      = 1,
    parameter int DATA_DEPTH = 512,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] in_tdata,
    input  logic [KSIZE-1:0] in_tkeep,
    input  logic             in_tuser,
    input  logic             in_tvalid,
    input  logic             in_tready,
    input  logic             in_tlast,
    output logic [DSIZE-1:0] out_tdata,
    output logic [KSIZE-1:0] out_tkeep,
    output logic             out_tuser,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic             data_full,
    output logic             pkt_full,
    output logic             data_empty,
    output logic             pkt_empty
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int PAW = $clog2(DEPTH);
    localparam int DW  = DSIZE + KSIZE + 1;
    localparam int PW  = 17;                 // {eq1, len_m1[15:0]}
    localparam logic [DAW:0] DONE = 1;
    localparam logic [PAW:0] PONE = 1;

    logic [DW-1:0] dmem_q [DATA_DEPTH];
    logic [PW-1:0] pmem_q [DEPTH];
    logic [DAW:0]  dwr_q, dwr_d, drd_q, drd_d;
    logic [PAW:0]  pwr_q, pwr_d, prd_q, prd_d;
    logic [15:0]   w_cnt_q, w_cnt_d, out_cnt_q, out_cnt_d;
    logic          w_acc, push_pkt, r_acc, pop_pkt;
    logic [DW-1:0] d_head;
    logic [PW-1:0] p_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign data_empty = (dwr_q == drd_q);
    assign data_full  = (dwr_q[DAW] != drd_q[DAW]) && (dwr_q[DAW-1:0] == drd_q[DAW-1:0]);
    assign pkt_empty  = (pwr_q == prd_q);
    assign pkt_full   = (pwr_q[PAW] != prd_q[PAW]) && (pwr_q[PAW-1:0] == prd_q[PAW-1:0]);

    // Full is taken before any same-cycle pop, so a full FIFO always drops the beat.
    assign w_acc    = in_tvalid & in_tready & ~data_full & ~pkt_full;
    assign push_pkt = w_acc & in_tlast;

    // Both FIFOs fall through: the head entry is read combinationally.
    assign d_head     = dmem_q[drd_q[DAW-1:0]];
    assign p_head     = pmem_q[prd_q[PAW-1:0]];
    assign out_tvalid = ~data_empty & ~pkt_empty;
    assign out_tlast  = out_tvalid & (p_head[16] | (out_cnt_q == p_head[15:0]));
    assign {out_tuser, out_tkeep, out_tdata} = d_head;
    assign r_acc      = out_tvalid & out_tready;
    assign pop_pkt    = r_acc & out_tlast;

    // Next-state for pointers and beat counters.
    always_comb begin
        dwr_d     = dwr_q;
        drd_d     = drd_q;
        pwr_d     = pwr_q;
        prd_d     = prd_q;
        w_cnt_d   = w_cnt_q;
        out_cnt_d = out_cnt_q;
        if (w_acc) begin
            dwr_d   = dwr_q + DONE;
            w_cnt_d = in_tlast ? 16'd0 : w_cnt_q + 16'd1;
        end
        if (push_pkt) pwr_d = pwr_q + PONE;
        if (r_acc) begin
            drd_d     = drd_q + DONE;
            out_cnt_d = out_tlast ? 16'd0 : out_cnt_q + 16'd1;
        end
        if (pop_pkt) prd_d = prd_q + PONE;
    end

    // State registers; reset drops everything, including a partial packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwr_q     <= '0;
            drd_q     <= '0;
            pwr_q     <= '0;
            prd_q     <= '0;
            w_cnt_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            dwr_q     <= dwr_d;
            drd_q     <= drd_d;
            pwr_q     <= pwr_d;
            prd_q     <= prd_d;
            w_cnt_q   <= w_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Storage arrays; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_acc)    dmem_q[dwr_q[DAW-1:0]] <= {in_tuser, in_tkeep, in_tdata};
        if (push_pkt) pmem_q[pwr_q[PAW-1:0]] <= {(w_cnt_q == 16'd0), w_cnt_q};
    end
endmodule

// File: tb/tb_sync_packet_mirror_fifo.sv
// Directed bench: a vector table for the streaming cases plus hand-written
// sequences for the packet-full, data-full and reset cases.
module tb_sync_packet_mirror_fifo;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_tdata;
    logic [0:0] in_tkeep;
    logic       in_tuser, in_tvalid, in_tready, in_tlast, out_tready;

    logic [7:0] a_tdata, b_tdata;
    logic [0:0] a_tkeep, b_tkeep;
    logic a_tuser, a_tvalid, a_tlast, a_dfull, a_pfull, a_dempty, a_pempty;
    logic b_tuser, b_tvalid, b_tlast, b_dfull, b_pfull, b_dempty, b_pempty;

    // Default configuration
    sync_packet_mirror_fifo dut (
        .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser(in_tuser),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .out_tdata(a_tdata), .out_tkeep(a_tkeep), .out_tuser(a_tuser), .out_tvalid(a_tvalid),
        .out_tready(out_tready), .out_tlast(a_tlast), .data_full(a_dfull), .pkt_full(a_pfull),
        .data_empty(a_dempty), .pkt_empty(a_pempty));

    // Tiny data FIFO for the data-full case
    sync_packet_mirror_fifo #(.DATA_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser(in_tuser),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .out_tdata(b_tdata), .out_tkeep(b_tkeep), .out_tuser(b_tuser), .out_tvalid(b_tvalid),
        .out_tready(out_tready), .out_tlast(b_tlast), .data_full(b_dfull), .pkt_full(b_pfull),
        .data_empty(b_dempty), .pkt_empty(b_pempty));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tuser/tkeep are derived from tdata so the packing order is checked too
    task automatic drive(input logic iv, input logic ir, input logic il, input logic [7:0] id,
                         input logic ordy);
        in_tvalid  = iv;
        in_tready  = ir;
        in_tlast   = il;
        in_tdata   = id;
        in_tkeep   = id[1];
        in_tuser   = id[0];
        out_tready = ordy;
    endtask

    typedef struct {
        logic       iv, ir, il;
        logic [7:0] id;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic       el, epe, ede, epf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic iv, logic ir, logic il, logic [7:0] id, logic ordy,
                                logic ev, logic [7:0] ed, logic el, logic epe, logic ede,
                                logic epf);
        vec_t v;
        v.iv = iv; v.ir = ir; v.il = il; v.id = id; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.el = el; v.epe = epe; v.ede = ede; v.epf = epf;
        return v;
    endfunction

    initial begin
        int npk;
        // Expected values describe outputs before the edge that consumes the inputs.
        //             iv ir il  id    ordy ev  ed    el pe de pf
        // single-beat packet
        vt.push_back(mk(1, 1, 1, 8'hA5, 0,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 0,  1, 8'hA5, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'hA5, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 1, 1, 0));
        // 4-beat packet, continuous drain
        vt.push_back(mk(1, 1, 0, 8'h01, 1,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(1, 1, 0, 8'h02, 1,  0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 8'h03, 1,  0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(1, 1, 1, 8'h04, 1,  0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h01, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h02, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h03, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h04, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 1, 1, 0));
        // valid without ready is not stored, then a 2-beat packet
        vt.push_back(mk(1, 0, 0, 8'h55, 1,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(1, 0, 0, 8'h56, 1,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(1, 0, 1, 8'h57, 1,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(1, 1, 0, 8'h10, 1,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(1, 1, 1, 8'h11, 1,  0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h10, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h11, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 1, 1, 0));
        // 3-beat packet drained with out_tready 1,0,1,0,1
        vt.push_back(mk(1, 1, 0, 8'h20, 0,  0, 8'h00, 0, 1, 1, 0));
        vt.push_back(mk(1, 1, 0, 8'h21, 0,  0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(1, 1, 1, 8'h22, 0,  0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h20, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 0,  1, 8'h21, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h21, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 0,  1, 8'h22, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  1, 8'h22, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 1, 1, 0));

        // ---- reset state ----
        rst = 1'b1;
        drive(0, 0, 0, 8'h00, 0);
        #1;
        check("rst_a_valid", a_tvalid, 0);
        check("rst_a_last", a_tlast, 0);
        check("rst_a_flags", {a_dempty, a_pempty, a_dfull, a_pfull}, 4'b1100);
        check("rst_b_flags", {b_dempty, b_pempty, b_dfull, b_pfull}, 4'b1100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- table-driven streaming ----
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].iv, vt[i].ir, vt[i].il, vt[i].id, vt[i].ordy);
            #1;
            check($sformatf("v%0d_valid", i), a_tvalid, vt[i].ev);
            check($sformatf("v%0d_last", i), a_tlast, vt[i].el);
            check($sformatf("v%0d_flags", i), {a_pempty, a_dempty, a_pfull, a_dfull},
                  {vt[i].epe, vt[i].ede, vt[i].epf, 1'b0});
            if (vt[i].ev)
                check($sformatf("v%0d_beat", i), {a_tuser, a_tkeep, a_tdata},
                      {vt[i].ed[0], vt[i].ed[1], vt[i].ed});
        end

        // ---- packet FIFO full: 5 single-beat packets, no drain ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 1, 1, 8'h30 + 8'(i), 0);
            @(negedge clk);
            drive(0, 0, 0, 8'h00, 0);
            #1;
            check($sformatf("pfull_after_%0d", i + 1), a_pfull, (i >= 3) ? 1 : 0);
        end
        npk = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 8'h00, 1);
            #1;
            if (a_tvalid) begin
                check($sformatf("pdrain_data%0d", npk), a_tdata, 8'h30 + 8'(npk));
                if (a_tlast) npk++;
            end
        end
        check("pdrain_count", npk, 4);
        check("pdrain_empty", {a_pempty, a_dempty, a_pfull}, 3'b110);

        // ---- data FIFO full on the 4-entry instance ----
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1, 1, (i == 5), 8'h40 + 8'(i), 0);
            @(negedge clk);
            drive(0, 0, 0, 8'h00, 0);
            #1;
            if (i == 3) check("dfull_after_4", b_dfull, 1);
        end
        check("dfull_no_pkt", {b_tvalid, b_pempty, b_dfull}, 3'b011);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 1);
        repeat (3) @(negedge clk);
        #1;
        check("dfull_valid_stays0", b_tvalid, 0);
        check("dfull_last0", b_tlast, 0);

        // ---- async reset discards stored beats ----
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst2_b_flags", {b_dempty, b_pempty, b_dfull, b_pfull}, 4'b1100);
        check("rst2_b_out", {b_tvalid, b_tlast}, 2'b00);
        check("rst2_a_flags", {a_dempty, a_pempty, a_dfull, a_pfull, a_tvalid, a_tlast},
              6'b110000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_b_valid", {b_tvalid, b_dempty}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
